// File: rtl/spi_mst_pkg.sv
// Shared definitions for the SPI mode-0 master: FSM state encoding and
// default parameter values.
package spi_mst_pkg;

    localparam int unsigned DATA_W_DEF = 8;
    localparam int unsigned DIV_DEF    = 2;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        SHIFT = 3'd2,
        NEXT  = 3'd3,
        HOLD  = 3'd4,
        GAP   = 3'd5
    } spi_mst_state_e;

endpackage

// File: rtl/spi_mst_sclkgen.sv
// SCLK divider for the SPI master.
// Ports:
//   PCLK, PRESET : clock, async active-high reset
//   en           : run the DIV counter (timed states)
//   toggle       : allow SCLK to toggle (SHIFT state)
//   tick         : counter at terminal count this cycle (combinational)
//   rise_pls     : SCLK goes high at the end of this cycle (combinational)
//   fall_pls     : SCLK goes low at the end of this cycle (combinational)
//   SCLK         : registered serial clock, idles low
module spi_mst_sclkgen
    import spi_mst_pkg::*;
#(
    parameter int unsigned DIV = DIV_DEF
) (
    input  logic PCLK,
    input  logic PRESET,
    input  logic en,
    input  logic toggle,
    output logic tick,
    output logic rise_pls,
    output logic fall_pls,
    output logic SCLK
);

    localparam int unsigned CW = $clog2(DIV + 1);

    logic [CW-1:0] cnt;

    assign tick     = en && (cnt == CW'(DIV - 1));
    assign rise_pls = tick && toggle && !SCLK;
    assign fall_pls = tick && toggle && SCLK;

    // Counter restarts from zero at every terminal count and whenever idle,
    // so each timed state begins on a fresh DIV window.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            cnt  <= '0;
            SCLK <= 1'b0;
        end else begin
            if (!en || tick) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
            if (rise_pls) begin
                SCLK <= 1'b1;
            end else if (fall_pls || !toggle) begin
                SCLK <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/spi_mst.sv
// SPI mode-0 master with valid/ready word interface and multi-word frames.
// Ports:
//   PCLK, PRESET      : clock, async active-high reset
//   tx_valid/tx_ready : word handshake (tx_ready depends on state and abort)
//   tx_data, tx_last  : word to send MSB first; tx_last closes the frame
//   abort             : closes a frame waiting in NEXT
//   rx_valid, rx_data : one-cycle pulse with the received word
//   busy              : not IDLE
//   SCLK, CS_N, MOSI  : serial outputs (registered); MISO : serial input
module spi_mst
    import spi_mst_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned DIV    = DIV_DEF
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              tx_valid,
    output logic              tx_ready,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_last,
    input  logic              abort,
    output logic              rx_valid,
    output logic [DATA_W-1:0] rx_data,
    output logic              busy,
    output logic              SCLK,
    output logic              CS_N,
    output logic              MOSI,
    input  logic              MISO
);

    localparam int unsigned BW = $clog2(DATA_W) + 1;

    spi_mst_state_e    state;
    spi_mst_state_e    state_nxt;
    logic [BW-1:0]     bit_cnt;
    logic [DATA_W-2:0] tx_sr;   // bits still to send after the one on MOSI
    logic [DATA_W-1:0] rx_sr;
    logic              last_q;
    logic              hs;
    logic              tick;
    logic              rise_pls;
    logic              fall_pls;
    logic              cnt_en;
    logic              in_shift;
    logic              shift_done;

    assign tx_ready   = (state == IDLE) || ((state == NEXT) && !abort);
    assign busy       = (state != IDLE);
    assign hs         = tx_valid && tx_ready;
    assign in_shift   = (state == SHIFT);
    assign cnt_en     = (state == SETUP) || (state == SHIFT) ||
                        (state == HOLD)  || (state == GAP);
    assign shift_done = fall_pls && (bit_cnt == BW'(DATA_W - 1));

    spi_mst_sclkgen #(
        .DIV (DIV)
    ) u_sclkgen (
        .PCLK     (PCLK),
        .PRESET   (PRESET),
        .en       (cnt_en),
        .toggle   (in_shift),
        .tick     (tick),
        .rise_pls (rise_pls),
        .fall_pls (fall_pls),
        .SCLK     (SCLK)
    );

    // State register
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; abort in NEXT overrides a pending handshake
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (hs) state_nxt = SETUP;
            SETUP:   if (tick) state_nxt = SHIFT;
            SHIFT:   if (shift_done) state_nxt = last_q ? HOLD : NEXT;
            NEXT: begin
                if (abort) begin
                    state_nxt = HOLD;
                end else if (hs) begin
                    state_nxt = SHIFT;
                end
            end
            HOLD:    if (tick) state_nxt = GAP;
            GAP:     if (tick) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: word capture, MOSI shift on falls, MISO sample on rises
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            CS_N     <= 1'b1;
            MOSI     <= 1'b0;
            rx_valid <= 1'b0;
            rx_data  <= '0;
            rx_sr    <= '0;
            tx_sr    <= '0;
            bit_cnt  <= '0;
            last_q   <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            CS_N     <= (state_nxt == IDLE) || (state_nxt == GAP);
            if (hs) begin
                tx_sr   <= tx_data[DATA_W-2:0];
                MOSI    <= tx_data[DATA_W-1];
                last_q  <= tx_last;
                bit_cnt <= '0;
            end else if (fall_pls) begin
                tx_sr   <= {tx_sr[DATA_W-3:0], 1'b0};
                MOSI    <= shift_done ? 1'b0 : tx_sr[DATA_W-2];
                bit_cnt <= shift_done ? '0 : bit_cnt + BW'(1);
            end
            if (rise_pls) begin
                rx_sr <= {rx_sr[DATA_W-2:0], MISO};
            end
            if (shift_done) begin
                rx_valid <= 1'b1;
                rx_data  <= rx_sr;
            end
        end
    end

endmodule
